// File: rtl/demultiplexor_tdm_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM encoding, channel count,
// default upstream latency and the channel-tag payload carried by the delay line.
package demultiplexor_tdm_pkg;

   localparam int unsigned NUM_CANALES      = 4;
   localparam int unsigned CANAL_W          = $clog2(NUM_CANALES);
   localparam int unsigned LATENCIA_DEFECTO = 1;
   localparam int unsigned LATENCIA_MAX     = 4;
   localparam int unsigned ESPERA_W         = $clog2(LATENCIA_MAX);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BARRIDO = 2'd1,
      ESPERA  = 2'd2
   } estado_t;

   // Tag travelling alongside the selector so capture knows which channel is arriving
   typedef struct packed {
      logic               valido;
      logic [CANAL_W-1:0] canal;
   } etiqueta_t;

   localparam int unsigned ETIQUETA_W = $bits(etiqueta_t);

endpackage

// File: rtl/demultiplexor_tdm_linea_retardo.sv
// Fixed-depth shift register with synchronous clear; aligns channel tags with
// the bits returning from the upstream registered multiplexer.
module linea_retardo #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] etapa [DEPTH];

   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            etapa[i] <= '0;
         end
      end else begin
         etapa[0] <= din;
         for (int i = 1; i < int'(DEPTH); i++) begin
            etapa[i] <= etapa[i-1];
         end
      end
   end

   assign dout = etapa[DEPTH-1];

endmodule

// File: rtl/demultiplexor_tdm.sv
// Sweeps the upstream 4:1 multiplexer through all channels and reassembles the
// returned serial bits into a parallel word, accounting for upstream latency.
module demultiplexor_tdm
   import demultiplexor_tdm_pkg::*;
#(
   parameter int unsigned LATENCIA = LATENCIA_DEFECTO
) (
   input  logic                   iClk,
   input  logic                   iReset,
   input  logic                   iInicio,
   input  logic                   iDato,
   output logic [CANAL_W-1:0]     oSelector,
   output logic [NUM_CANALES-1:0] oDatos,
   output logic                   oListo,
   output logic                   oOcupado,
   output logic                   oError
);

   estado_t                estado;
   logic [ESPERA_W-1:0]    cuenta_espera;
   logic                   inicio_prev;
   logic [NUM_CANALES-2:0] sombra;
   etiqueta_t              tag_entrada;
   etiqueta_t              tag_salida;

   // A tag is launched every cycle the selector is presenting a real channel
   always_comb begin
      tag_entrada.valido = (estado == BARRIDO);
      tag_entrada.canal  = oSelector;
   end

   linea_retardo #(
      .DEPTH (LATENCIA),
      .WIDTH (ETIQUETA_W)
   ) u_linea_retardo (
      .clk   (iClk),
      .clear (iReset),
      .din   (tag_entrada),
      .dout  (tag_salida)
   );

   // Sweep sequencer. Starting is level-sensitive so a held request chains sweeps;
   // rejection is edge-sensitive so a held request never counts as a collision.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         estado        <= IDLE;
         oSelector     <= '0;
         oOcupado      <= 1'b0;
         oError        <= 1'b0;
         cuenta_espera <= '0;
         inicio_prev   <= 1'b0;
      end else begin
         inicio_prev <= iInicio;
         if (iInicio && !inicio_prev && oOcupado) begin
            oError <= 1'b1;
         end
         case (estado)
            IDLE: begin
               if (iInicio) begin
                  estado    <= BARRIDO;
                  oSelector <= '0;
                  oOcupado  <= 1'b1;
               end
            end
            BARRIDO: begin
               if (oSelector == CANAL_W'(NUM_CANALES - 1)) begin
                  estado        <= ESPERA;
                  oSelector     <= '0;
                  cuenta_espera <= '0;
               end else begin
                  oSelector <= oSelector + CANAL_W'(1);
               end
            end
            ESPERA: begin
               if (cuenta_espera == ESPERA_W'(LATENCIA - 1)) begin
                  estado   <= IDLE;
                  oOcupado <= 1'b0;
               end else begin
                  cuenta_espera <= cuenta_espera + ESPERA_W'(1);
               end
            end
            default: begin
               estado    <= IDLE;
               oSelector <= '0;
               oOcupado  <= 1'b0;
            end
         endcase
      end
   end

   // Capture driven purely by the delayed tag; the last channel publishes the word
   always_ff @(posedge iClk) begin
      if (iReset) begin
         sombra <= '0;
         oDatos <= '0;
         oListo <= 1'b0;
      end else begin
         oListo <= 1'b0;
         if (tag_salida.valido) begin
            case (tag_salida.canal)
               CANAL_W'(0): sombra[0] <= iDato;
               CANAL_W'(1): sombra[1] <= iDato;
               CANAL_W'(2): sombra[2] <= iDato;
               default: begin
                  oDatos <= {iDato, sombra};
                  oListo <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_demultiplexor_tdm.sv
// Directed table-driven bench for demultiplexor_tdm at latencies 1 and 3, with a
// behavioural registered 4:1 multiplexer feeding iDato back from oSelector.
module tb_demultiplexor_tdm;

   logic iClk = 1'b0;
   always #5 iClk = ~iClk;

   logic       rst1, ini1, dato1, listo1, ocup1, err1;
   logic [1:0] sel1;
   logic [3:0] datos1;
   logic       rst3, ini3, dato3, listo3, ocup3, err3;
   logic [1:0] sel3;
   logic [3:0] datos3;

   demultiplexor_tdm #(.LATENCIA(1)) dut1 (
      .iClk(iClk), .iReset(rst1), .iInicio(ini1), .iDato(dato1),
      .oSelector(sel1), .oDatos(datos1), .oListo(listo1), .oOcupado(ocup1), .oError(err1)
   );

   demultiplexor_tdm #(.LATENCIA(3)) dut3 (
      .iClk(iClk), .iReset(rst3), .iInicio(ini3), .iDato(dato3),
      .oSelector(sel3), .oDatos(datos3), .oListo(listo3), .oOcupado(ocup3), .oError(err3)
   );

   // Upstream multiplexer model: output is word[selector seen LATENCIA edges ago]
   logic [3:0] word1, word3;
   logic [1:0] hist1;
   logic [1:0] hist3 [3];

   always @(posedge iClk) begin
      hist1    <= sel1;
      hist3[0] <= sel3;
      hist3[1] <= hist3[0];
      hist3[2] <= hist3[1];
   end

   assign dato1 = word1[hist1];
   assign dato3 = word3[hist3[2]];

   typedef struct {
      logic       rst;
      logic       ini;
      logic [3:0] word;
      logic       chk;
      logic [1:0] sel;
      logic [3:0] datos;
      logic       listo;
      logic       ocup;
      logic       err;
   } vec_t;

   vec_t tab1[$];
   vec_t tab3[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t row(input logic rst, input logic ini, input logic [3:0] word,
                                input logic chk, input logic [1:0] sel, input logic [3:0] datos,
                                input logic listo, input logic ocup, input logic err);
      vec_t v;
      v.rst = rst; v.ini = ini; v.word = word; v.chk = chk; v.sel = sel;
      v.datos = datos; v.listo = listo; v.ocup = ocup; v.err = err;
      return v;
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input bit d3, input vec_t v);
      if (d3) begin
         check({tag, "_sel"},   4'(sel3),   4'(v.sel));
         check({tag, "_datos"}, datos3,     v.datos);
         check({tag, "_listo"}, 4'(listo3), 4'(v.listo));
         check({tag, "_ocup"},  4'(ocup3),  4'(v.ocup));
         check({tag, "_err"},   4'(err3),   4'(v.err));
      end else begin
         check({tag, "_sel"},   4'(sel1),   4'(v.sel));
         check({tag, "_datos"}, datos1,     v.datos);
         check({tag, "_listo"}, 4'(listo1), 4'(v.listo));
         check({tag, "_ocup"},  4'(ocup1),  4'(v.ocup));
         check({tag, "_err"},   4'(err1),   4'(v.err));
      end
   endtask

   // Drive one cycle's inputs just after the edge, check mid-cycle, advance
   task automatic run(input vec_t v, input bit d3, input int idx);
      if (d3) begin
         rst3 = v.rst; ini3 = v.ini; word3 = v.word;
      end else begin
         rst1 = v.rst; ini1 = v.ini; word1 = v.word;
      end
      @(negedge iClk);
      if (v.chk) check_all($sformatf("lat%0d_row%0d", d3 ? 3 : 1, idx), d3, v);
      @(posedge iClk);
      #1;
   endtask

   initial begin
      vec_t zero;
      zero = row(0, 0, 4'b0000, 1, 2'd0, 4'b0000, 0, 0, 0);

      // A: single sweep, latency 1, data 1010
      tab1.push_back(row(0, 1, 4'b1010, 1, 2'd0, 4'b0000, 0, 0, 0));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd0, 4'b0000, 0, 1, 0));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd1, 4'b0000, 0, 1, 0));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd2, 4'b0000, 0, 1, 0));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd3, 4'b0000, 0, 1, 0));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd0, 4'b0000, 0, 1, 0));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd0, 4'b1010, 1, 0, 0));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd0, 4'b1010, 0, 0, 0));
      // B: busy rejection in cycle 3
      tab1.push_back(row(1, 0, 4'b1010, 0, 2'd0, 4'b0000, 0, 0, 0));
      tab1.push_back(row(0, 1, 4'b1010, 1, 2'd0, 4'b0000, 0, 0, 0));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd0, 4'b0000, 0, 1, 0));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd1, 4'b0000, 0, 1, 0));
      tab1.push_back(row(0, 1, 4'b1010, 1, 2'd2, 4'b0000, 0, 1, 0));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd3, 4'b0000, 0, 1, 1));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd0, 4'b0000, 0, 1, 1));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd0, 4'b1010, 1, 0, 1));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd0, 4'b1010, 0, 0, 1));
      tab1.push_back(row(0, 0, 4'b1010, 1, 2'd0, 4'b1010, 0, 0, 1));
      // C: held start, back-to-back sweeps 0110 then 1001
      tab1.push_back(row(1, 0, 4'b0110, 0, 2'd0, 4'b0000, 0, 0, 0));
      tab1.push_back(row(0, 1, 4'b0110, 1, 2'd0, 4'b0000, 0, 0, 0));
      for (int k = 0; k < 4; k++)
         tab1.push_back(row(0, 1, 4'b0110, 1, 2'(k), 4'b0000, 0, 1, 0));
      tab1.push_back(row(0, 1, 4'b0110, 1, 2'd0, 4'b0000, 0, 1, 0));
      tab1.push_back(row(0, 1, 4'b1001, 1, 2'd0, 4'b0110, 1, 0, 0));
      for (int k = 0; k < 4; k++)
         tab1.push_back(row(0, 1, 4'b1001, 1, 2'(k), 4'b0110, 0, 1, 0));
      tab1.push_back(row(0, 1, 4'b1001, 1, 2'd0, 4'b0110, 0, 1, 0));
      tab1.push_back(row(0, 0, 4'b1001, 1, 2'd0, 4'b1001, 1, 0, 0));
      tab1.push_back(row(0, 0, 4'b1001, 1, 2'd0, 4'b1001, 0, 0, 0));
      // D: reset (with simultaneous start) in cycle 3 of a sweep
      tab1.push_back(row(1, 0, 4'b1111, 0, 2'd0, 4'b0000, 0, 0, 0));
      tab1.push_back(row(0, 1, 4'b1111, 1, 2'd0, 4'b0000, 0, 0, 0));
      tab1.push_back(row(0, 0, 4'b1111, 1, 2'd0, 4'b0000, 0, 1, 0));
      tab1.push_back(row(0, 0, 4'b1111, 1, 2'd1, 4'b0000, 0, 1, 0));
      tab1.push_back(row(1, 1, 4'b1111, 1, 2'd2, 4'b0000, 0, 1, 0));
      for (int k = 0; k < 5; k++) begin
         zero.word = 4'b1111;
         tab1.push_back(zero);
      end
      // E: latency 3, data 1100
      tab3.push_back(row(1, 0, 4'b1100, 0, 2'd0, 4'b0000, 0, 0, 0));
      tab3.push_back(row(0, 1, 4'b1100, 1, 2'd0, 4'b0000, 0, 0, 0));
      for (int k = 0; k < 4; k++)
         tab3.push_back(row(0, 0, 4'b1100, 1, 2'(k), 4'b0000, 0, 1, 0));
      for (int k = 0; k < 3; k++)
         tab3.push_back(row(0, 0, 4'b1100, 1, 2'd0, 4'b0000, 0, 1, 0));
      tab3.push_back(row(0, 0, 4'b1100, 1, 2'd0, 4'b1100, 1, 0, 0));
      tab3.push_back(row(0, 0, 4'b1100, 1, 2'd0, 4'b1100, 0, 0, 0));

      // Reset both instances for two cycles with random request and data
      rst1 = 1'b1; rst3 = 1'b1;
      word1 = 4'($urandom); word3 = 4'($urandom);
      for (int c = 0; c < 2; c++) begin
         ini1 = 1'($urandom); ini3 = 1'($urandom);
         @(posedge iClk);
         #1;
      end
      @(negedge iClk);
      check_all("reset_lat1", 1'b0, row(1, 0, 4'b0000, 1, 2'd0, 4'b0000, 0, 0, 0));
      check_all("reset_lat3", 1'b1, row(1, 0, 4'b0000, 1, 2'd0, 4'b0000, 0, 0, 0));
      @(posedge iClk);
      #1;

      foreach (tab1[i]) run(tab1[i], 1'b0, i);
      rst1 = 1'b0; ini1 = 1'b0;
      foreach (tab3[i]) run(tab3[i], 1'b1, i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demultiplexor_tdm.md
DEMULTIPLEXOR_TDM -- requirements
Module: demultiplexor_tdm

Interface
REQ-001 The block SHALL have parameter LATENCIA, default 1, meaning the number of clock cycles from oSelector to the matching bit on iDato; legal values are 1..4.
REQ-002 The block SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port iReset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port iInicio, input, 1 bit: request to start a 4-channel capture sweep.
REQ-005 The block SHALL have port iDato, input, 1 bit: serial bit returned by the upstream 4:1 registered multiplexer.
REQ-006 The block SHALL have port oSelector, output, 2 bits: channel select driven to the upstream multiplexer.
REQ-007 The block SHALL have port oDatos, output, 4 bits: captured parallel word; bit k is channel k.
REQ-008 The block SHALL have port oListo, output, 1 bit: one-cycle pulse marking a new oDatos.
REQ-009 The block SHALL have port oOcupado, output, 1 bit: high while a sweep is in progress.
REQ-010 The block SHALL have port oError, output, 1 bit: sticky flag for an iInicio rejected while busy.

Function
REQ-011 States SHALL be IDLE, BARRIDO and ESPERA.
- IDLE -> BARRIDO when iInicio=1.
- BARRIDO lasts exactly 4 cycles, then -> ESPERA.
- ESPERA lasts exactly LATENCIA cycles, then -> IDLE.
REQ-012 Cycle numbering: cycle 0 is the cycle in which iInicio=1 is sampled in IDLE. oSelector SHALL equal k during cycle k+1 (k=0..3), and 2'b00 at all other times.
REQ-013 The bit for channel k SHALL be sampled from iDato at the rising edge ending cycle k+1+LATENCIA.
- Capture SHALL use a channel-tag delay line, not state decoding.
- Capture therefore overlaps BARRIDO when LATENCIA<4.
REQ-014 Captured bits 0..2 SHALL be held in an internal shadow register. oDatos SHALL update only as a whole word, at the edge sampling channel 3: oDatos = {iDato, shadow[2:0]}.
REQ-015 oListo SHALL be high for exactly one cycle, cycle 5+LATENCIA, the first cycle in which the new oDatos is visible; oDatos SHALL hold until the next completed sweep.
REQ-016 oOcupado SHALL be high in cycles 1..4+LATENCIA and low in cycle 5+LATENCIA. An iInicio sampled in cycle 5+LATENCIA SHALL start a new sweep with no gap cycle.
REQ-017 iInicio=1 while oOcupado=1:
- SHALL be ignored.
- SHALL set oError in the next cycle.
- oError SHALL remain set until iReset; the sweep in progress SHALL complete unaffected.
REQ-018 iInicio held high continuously SHALL produce back-to-back sweeps with one oListo per sweep. It SHALL NOT set oError in cycle 5+LATENCIA, where the block is idle.
REQ-019 iDato outside the capture edges of REQ-013 SHALL be ignored.

Reset
REQ-020 With iReset=1 at a rising edge, the next cycle SHALL have:
- state IDLE;
- oSelector=2'b00, oDatos=4'b0000, oListo=0, oOcupado=0, oError=0;
- shadow register and delay line cleared.
REQ-021 Reset mid-sweep SHALL discard the partial word; no oListo SHALL follow. iReset SHALL take priority over iInicio in the same cycle.

Structure
REQ-022 A shared package SHALL hold the following; the block SHALL import them and SHALL NOT redefine them locally:
- the state encoding (IDLE/BARRIDO/ESPERA);
- constant NUM_CANALES=4;
- default LATENCIA=1.
REQ-023 The channel-tag delay line SHALL be a sub-module named linea_retardo:
- parameters: depth and width;
- carries a valid bit plus a 2-bit channel index;
- synchronous active-high clear.

Verification
REQ-024 Reset: assert iReset for 2 cycles with random iInicio and iDato -> all outputs at REQ-020 values, oSelector=00.
REQ-025 Single sweep, LATENCIA=1, bench multiplexer model loaded with 4'b1010 -> oSelector 0,1,2,3 in cycles 1..4; oListo only in cycle 6; oDatos=4'b1010; oOcupado high in cycles 1..5.
REQ-026 Busy rejection: iInicio pulsed in cycle 3 -> oError=1 from cycle 4 and stays set; oDatos still 1010 at cycle 6; no second sweep starts.
REQ-027 Back-to-back: iInicio held high with model data 4'b0110 then 4'b1001 -> oListo in cycles 6 and 12; oDatos 0110 then 1001; oError stays 0.
REQ-028 Reset mid-sweep: iReset in cycle 3 -> cycle 4 shows oOcupado=0 and oSelector=00; no oListo appears; oDatos=0000.
REQ-029 LATENCIA=3 with model data 4'b1100 -> oListo in cycle 8; oDatos=1100; oOcupado high in cycles 1..7.
